// File: rtl/frame_reader_if.sv
// frame_reader_if: start/buffer control, memory read port and pixel stream of the frame reader.
interface frame_reader_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              buf_sel;
  logic [22:0]       rd_addr;
  logic              rd_req;
  logic              rd_wait;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [9:0]        pix_x;
  logic [8:0]        pix_y;
  logic              sof;
  logic              eol;
  logic              busy;
  logic              done;
  modport slave (
    input  start, buf_sel, rd_wait, rd_data_valid, rd_data, pix_ready,
    output rd_addr, rd_req, pix_data, pix_valid, pix_x, pix_y, sof, eol, busy, done
  );
  modport master (
    output start, buf_sel, rd_wait, rd_data_valid, rd_data, pix_ready,
    input  rd_addr, rd_req, pix_data, pix_valid, pix_x, pix_y, sof, eol, busy, done
  );
endinterface

// File: rtl/frame_reader.sv
// frame_reader: streams one raster frame out of a double-buffered frame store through a
// credit-limited show-ahead FIFO, so returned read data is never dropped under backpressure.
module frame_reader #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  frame_reader_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [18:0]   LAST   = 19'(H_RES * V_RES - 1);
  localparam logic [22:0]   BASE1  = 23'(H_RES * V_RES);
  localparam logic [9:0]    X_LAST = 10'(H_RES - 1);
  localparam logic [8:0]    Y_LAST = 9'(V_RES - 1);
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [22:0]       base_q, base_d, addr_q, addr_d;
  logic [18:0]       cnt_q, cnt_d;
  logic              req_q, req_d, done_q, done_d;
  logic [CW-1:0]     credit_q, credit_d, occ_q, occ_d;
  logic [PW-1:0]     wr_q, rd_q;
  logic [9:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              acc, push, pop, valid;
  // credit counts reads in flight plus FIFO occupancy; a return with no read in flight is dropped
  assign valid    = occ_q != '0;
  assign acc      = req_q & ~bus.rd_wait;
  assign pop      = valid & bus.pix_ready;
  assign push     = bus.rd_data_valid & (credit_q > occ_q);
  assign credit_d = credit_q + CW'(acc) - CW'(pop);
  assign occ_d    = occ_q + CW'(push) - CW'(pop);
  assign bus.rd_req    = req_q;
  assign bus.rd_addr   = addr_q;
  assign bus.pix_valid = valid;
  assign bus.pix_data  = valid ? mem[rd_q] : '0;
  assign bus.pix_x     = x_q;
  assign bus.pix_y     = y_q;
  assign bus.sof       = valid & (x_q == '0) & (y_q == '0);
  assign bus.eol       = valid & (x_q == X_LAST);
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        base_d  = bus.buf_sel ? BASE1 : '0;
        cnt_d   = '0;
        x_d     = '0;
        y_d     = '0;
        req_d   = 1'b1;
        addr_d  = base_d;
        state_d = READ;
      end
      READ: begin
        if (acc && cnt_q == LAST) begin
          req_d   = 1'b0;
          state_d = DRAIN;
        end else if (acc || !req_q) begin
          cnt_d  = cnt_q + 19'(acc);
          req_d  = credit_d < DEPTH;
          addr_d = base_q + {4'd0, cnt_d};
        end
      end
      default: ;
    endcase
    if (pop) begin
      x_d = (x_q == X_LAST) ? '0 : x_q + 10'd1;
      y_d = (x_q == X_LAST) ? y_q + 9'd1 : y_q;
      if (x_q == X_LAST && y_q == Y_LAST) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
      credit_q <= '0;
      occ_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      done_q   <= done_d;
      credit_q <= credit_d;
      occ_q    <= occ_d;
      wr_q     <= wr_q + PW'(push);
      rd_q     <= rd_q + PW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= bus.rd_data;
  end
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: 4x2 frame, depth-4 FIFO, memory model with 1-cycle latency returning A000^addr.
module tb_frame_reader;
  localparam int H = 4, V = 2, D = 4, W = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  frame_reader_if #(.DATA_W(W)) bus ();
  frame_reader #(.H_RES(H), .V_RES(V), .DATA_W(W), .FIFO_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic model_v = 1'b0, inj_v = 1'b0;
  logic [W-1:0] model_d = '0;
  always @(posedge clk) begin
    model_v <= bus.rd_req & ~bus.rd_wait;
    model_d <= 16'hA000 ^ bus.rd_addr[15:0];
  end
  assign bus.rd_data_valid = model_v | inj_v;
  assign bus.rd_data       = inj_v ? 16'hDEAD : model_d;
  typedef struct {
    logic st, rdy, req, pv, sof, eol, busy, done;
    logic [22:0] addr;
    logic [15:0] pd;
    logic [9:0]  x;
    logic [8:0]  y;
  } vec_t;
  vec_t vt[13];
  int checks = 0, errors = 0, ndone = 0;
  bit win_chk = 1'b0;
  logic [22:0] q_addr[$];
  logic [W-1:0] q_pd[$];
  int q_x[$], q_y[$];
  bit q_sof[$], q_eol[$];
  function automatic vec_t mk(int st, int rdy, int req, int addr, int pv, int pd, int x, int y,
                              int sof, int eol, int busy, int done);
    mk.st = st != 0; mk.rdy = rdy != 0; mk.req = req != 0; mk.addr = 23'(addr);
    mk.pv = pv != 0; mk.pd = 16'(pd); mk.x = 10'(x); mk.y = 9'(y);
    mk.sof = sof != 0; mk.eol = eol != 0; mk.busy = busy != 0; mk.done = done != 0;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step();
    if (win_chk && bus.rd_req) chk("addr window", 32'(bus.rd_addr >= 23'd8 && bus.rd_addr <= 23'd15), 1);
    if (bus.rd_req && !bus.rd_wait) q_addr.push_back(bus.rd_addr);
    if (bus.pix_valid && bus.pix_ready) begin
      q_pd.push_back(bus.pix_data);
      q_x.push_back(int'(bus.pix_x));
      q_y.push_back(int'(bus.pix_y));
      q_sof.push_back(bus.sof);
      q_eol.push_back(bus.eol);
    end
    if (bus.done) ndone++;
    @(negedge clk);
  endtask
  task automatic clr();
    q_addr.delete(); q_pd.delete(); q_x.delete(); q_y.delete(); q_sof.delete(); q_eol.delete();
    ndone = 0;
  endtask
  task automatic start_frame(input logic bs);
    bus.buf_sel = bs; bus.start = 1'b1; step(); bus.start = 1'b0;
  endtask
  task automatic wait_done(input string n);
    int k = 0;
    while (ndone == 0 && k < 100) begin step(); k++; end
    chk({n, " done seen"}, 32'(ndone > 0), 1);
    repeat (3) step();
  endtask
  task automatic check_frame(input string n, input int base);
    chk({n, " nreq"}, q_addr.size(), 8);
    chk({n, " npix"}, q_pd.size(), 8);
    chk({n, " ndone"}, ndone, 1);
    for (int i = 0; i < 8; i++) begin
      if (i < q_addr.size()) chk({n, " req addr"}, 32'(q_addr[i]), base + i);
      if (i < q_pd.size()) begin
        chk({n, " pix data"}, 32'(q_pd[i]), 32'h0000A000 ^ (base + i));
        chk({n, " pix x"}, q_x[i], i % 4);
        chk({n, " pix y"}, q_y[i], i / 4);
        chk({n, " sof"}, 32'(q_sof[i]), 32'(i == 0));
        chk({n, " eol"}, 32'(q_eol[i]), 32'(i % 4 == 3));
      end
    end
  endtask
  task automatic chk_reset(input string n);
    chk({n, " rd_req"}, 32'(bus.rd_req), 0);
    chk({n, " rd_addr"}, 32'(bus.rd_addr), 0);
    chk({n, " pix_valid"}, 32'(bus.pix_valid), 0);
    chk({n, " pix_data"}, 32'(bus.pix_data), 0);
    chk({n, " pix_x"}, 32'(bus.pix_x), 0);
    chk({n, " pix_y"}, 32'(bus.pix_y), 0);
    chk({n, " sof"}, 32'(bus.sof), 0);
    chk({n, " eol"}, 32'(bus.eol), 0);
    chk({n, " busy"}, 32'(bus.busy), 0);
    chk({n, " done"}, 32'(bus.done), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b0; bus.buf_sel = 1'b0; bus.pix_ready = 1'b0; bus.rd_wait = 1'b0;
    vt[0]  = mk(1, 1, 0, 0,  0, 0,       0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 1, 8,  0, 0,       0, 0, 0, 0, 1, 0);
    vt[2]  = mk(0, 1, 1, 9,  0, 0,       0, 0, 0, 0, 1, 0);
    vt[3]  = mk(0, 1, 1, 10, 1, 'hA008, 0, 0, 1, 0, 1, 0);
    vt[4]  = mk(0, 1, 1, 11, 1, 'hA009, 1, 0, 0, 0, 1, 0);
    vt[5]  = mk(0, 1, 1, 12, 1, 'hA00A, 2, 0, 0, 0, 1, 0);
    vt[6]  = mk(0, 1, 1, 13, 1, 'hA00B, 3, 0, 0, 1, 1, 0);
    vt[7]  = mk(0, 1, 1, 14, 1, 'hA00C, 0, 1, 0, 0, 1, 0);
    vt[8]  = mk(0, 1, 1, 15, 1, 'hA00D, 1, 1, 0, 0, 1, 0);
    vt[9]  = mk(0, 1, 0, 0,  1, 'hA00E, 2, 1, 0, 0, 1, 0);
    vt[10] = mk(0, 1, 0, 0,  1, 'hA00F, 3, 1, 0, 1, 1, 0);
    vt[11] = mk(0, 1, 0, 0,  0, 0,       0, 0, 0, 0, 0, 1);
    vt[12] = mk(0, 1, 0, 0,  0, 0,       0, 0, 0, 0, 0, 0);
    // reset held with random inputs, start included
    repeat (4) begin
      bus.start = 1'($urandom); bus.buf_sel = 1'($urandom); bus.pix_ready = 1'($urandom);
      bus.rd_wait = 1'($urandom); inj_v = 1'($urandom);
      @(negedge clk);
      chk_reset("reset");
    end
    bus.start = 1'b0; bus.rd_wait = 1'b0; inj_v = 1'b0;
    rst_n = 1'b1;
    step();
    chk_reset("after release");
    // nominal frame, cycle by cycle
    bus.buf_sel = 1'b1;
    for (int k = 0; k < 13; k++) begin
      bus.start = vt[k].st; bus.pix_ready = vt[k].rdy;
      chk("nom rd_req", 32'(bus.rd_req), 32'(vt[k].req));
      if (vt[k].req) chk("nom rd_addr", 32'(bus.rd_addr), 32'(vt[k].addr));
      chk("nom pix_valid", 32'(bus.pix_valid), 32'(vt[k].pv));
      if (vt[k].pv) begin
        chk("nom pix_data", 32'(bus.pix_data), 32'(vt[k].pd));
        chk("nom pix_x", 32'(bus.pix_x), 32'(vt[k].x));
        chk("nom pix_y", 32'(bus.pix_y), 32'(vt[k].y));
      end
      chk("nom sof", 32'(bus.sof), 32'(vt[k].sof));
      chk("nom eol", 32'(bus.eol), 32'(vt[k].eol));
      chk("nom busy", 32'(bus.busy), 32'(vt[k].busy));
      chk("nom done", 32'(bus.done), 32'(vt[k].done));
      step();
    end
    // backpressure: credit stops requests at FIFO depth
    clr();
    bus.pix_ready = 1'b0;
    start_frame(1'b1);
    repeat (12) step();
    chk("bp nreq stalled", q_addr.size(), 4);
    chk("bp rd_req low", 32'(bus.rd_req), 0);
    chk("bp fifo holds", 32'(bus.pix_valid), 1);
    bus.pix_ready = 1'b1;
    wait_done("bp");
    check_frame("bp", 8);
    // memory stall on address 10
    clr();
    start_frame(1'b1);
    for (int n = 0; n < 30 && !(bus.rd_req && bus.rd_addr == 23'd10); n++) step();
    bus.rd_wait = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("stall rd_req", 32'(bus.rd_req), 1);
      chk("stall rd_addr", 32'(bus.rd_addr), 10);
      step();
    end
    bus.rd_wait = 1'b0;
    chk("stall accept addr", 32'(bus.rd_addr), 10);
    step();
    chk("stall next rd_req", 32'(bus.rd_req), 1);
    chk("stall next addr", 32'(bus.rd_addr), 11);
    wait_done("stall");
    check_frame("stall", 8);
    // start and buf_sel changes mid-frame are ignored
    clr();
    win_chk = 1'b1;
    start_frame(1'b1);
    repeat (3) step();
    bus.start = 1'b1; bus.buf_sel = 1'b0; step();
    bus.start = 1'b0; bus.buf_sel = 1'b1; step();
    bus.buf_sel = 1'b0;
    wait_done("ign");
    repeat (8) step();
    win_chk = 1'b0;
    chk("ign idle", 32'(bus.busy), 0);
    check_frame("ign", 8);
    // reset mid-frame, then late returns must be dropped
    clr();
    start_frame(1'b1);
    for (int n = 0; n < 30 && q_addr.size() < 3; n++) step();
    chk("mid nreq", q_addr.size(), 3);
    rst_n = 1'b0;
    step(); step();
    chk_reset("mid reset");
    rst_n = 1'b1;
    inj_v = 1'b1;
    repeat (3) begin
      step();
      chk("late drop pix_valid", 32'(bus.pix_valid), 0);
    end
    inj_v = 1'b0;
    step();
    chk("late drop final", 32'(bus.pix_valid), 0);
    chk("late drop busy", 32'(bus.busy), 0);
    clr();
    start_frame(1'b0);
    wait_done("post");
    check_frame("post", 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
